// File: rtl/i_decode.sv
// MIPS instruction-decode stage: register file, control decoder, sign extender and ID/EX latch.
// Optional load-use stall detection is built when LOAD_USE_HAZARD_EN is defined.
module i_decode #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] IF_ID_instr,
  input  logic [WIDTH-1:0] IF_ID_npc,
  input  logic             MEM_WB_RegWrite,
  input  logic [4:0]       MEM_WB_WriteReg,
  input  logic [WIDTH-1:0] MEM_WB_WriteData,
  output logic [1:0]       ID_EX_wb,
  output logic [2:0]       ID_EX_m,
  output logic [3:0]       ID_EX_ex,
  output logic [WIDTH-1:0] ID_EX_npc,
  output logic [WIDTH-1:0] ID_EX_readdat1,
  output logic [WIDTH-1:0] ID_EX_readdat2,
  output logic [WIDTH-1:0] ID_EX_sign_ext,
  output logic [4:0]       ID_EX_rs,
  output logic [4:0]       ID_EX_rt,
  output logic [4:0]       ID_EX_rd,
  output logic             stall
);

  localparam int unsigned REG_AW = 5;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned OP_W   = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;

  // Instruction field split
  logic [OP_W-1:0]   opcode;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [IMM_W-1:0]  imm;

  assign opcode = IF_ID_instr[31:26];
  assign rs     = IF_ID_instr[25:21];
  assign rt     = IF_ID_instr[20:16];
  assign rd     = IF_ID_instr[15:11];
  assign imm    = IF_ID_instr[15:0];

  // Register file; $0 is never written so it always reads zero
  logic [WIDTH-1:0] regs [NREGS];
  logic             wr_en;

  assign wr_en = MEM_WB_RegWrite && (MEM_WB_WriteReg != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[MEM_WB_WriteReg] <= MEM_WB_WriteData;
    end
  end

  // Reads bypass a same-cycle writeback so WB->ID needs no extra forwarding
  logic [WIDTH-1:0] rd_data1;
  logic [WIDTH-1:0] rd_data2;

  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (wr_en && (MEM_WB_WriteReg == rs)) begin
      rd_data1 = MEM_WB_WriteData;
    end else if (rs != '0) begin
      rd_data1 = regs[rs];
    end
    if (wr_en && (MEM_WB_WriteReg == rt)) begin
      rd_data2 = MEM_WB_WriteData;
    end else if (rt != '0) begin
      rd_data2 = regs[rt];
    end
  end

  // Main control decoder; unknown opcodes become a bubble
  logic [1:0] wb_ctl;
  logic [2:0] m_ctl;
  logic [3:0] ex_ctl;

  always_comb begin
    wb_ctl = 2'b00;
    m_ctl  = 3'b000;
    ex_ctl = 4'b0000;
    unique case (opcode)
      OP_RTYPE: begin
        wb_ctl = 2'b10;
        m_ctl  = 3'b000;
        ex_ctl = 4'b1100;
      end
      OP_LW: begin
        wb_ctl = 2'b11;
        m_ctl  = 3'b010;
        ex_ctl = 4'b0001;
      end
      OP_SW: begin
        wb_ctl = 2'b00;
        m_ctl  = 3'b001;
        ex_ctl = 4'b0001;
      end
      OP_BEQ: begin
        wb_ctl = 2'b00;
        m_ctl  = 3'b100;
        ex_ctl = 4'b0010;
      end
      default: begin
        wb_ctl = 2'b00;
        m_ctl  = 3'b000;
        ex_ctl = 4'b0000;
      end
    endcase
  end

  logic [WIDTH-1:0] sign_ext;

  assign sign_ext = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};

`ifdef LOAD_USE_HAZARD_EN
  // A load in EX whose destination feeds the instruction in ID forces a one-cycle bubble
  assign stall = ID_EX_m[1] && (ID_EX_rt != '0) &&
                 ((ID_EX_rt == rs) || (ID_EX_rt == rt));
`else
  assign stall = 1'b0;
`endif

  // ID/EX pipeline latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ID_EX_wb       <= '0;
      ID_EX_m        <= '0;
      ID_EX_ex       <= '0;
      ID_EX_npc      <= '0;
      ID_EX_readdat1 <= '0;
      ID_EX_readdat2 <= '0;
      ID_EX_sign_ext <= '0;
      ID_EX_rs       <= '0;
      ID_EX_rt       <= '0;
      ID_EX_rd       <= '0;
    end else begin
      if (stall) begin
        ID_EX_wb <= '0;
        ID_EX_m  <= '0;
        ID_EX_ex <= '0;
      end else begin
        ID_EX_wb <= wb_ctl;
        ID_EX_m  <= m_ctl;
        ID_EX_ex <= ex_ctl;
      end
      ID_EX_npc      <= IF_ID_npc;
      ID_EX_readdat1 <= rd_data1;
      ID_EX_readdat2 <= rd_data2;
      ID_EX_sign_ext <= sign_ext;
      ID_EX_rs       <= rs;
      ID_EX_rt       <= rt;
      ID_EX_rd       <= rd;
    end
  end

endmodule

// File: tb/tb_i_decode.sv
// Directed self-checking bench for i_decode; stall expectations follow LOAD_USE_HAZARD_EN.
module tb_i_decode;

  logic        clk;
  logic        rst_n;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_npc;
  logic        MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_WriteReg;
  logic [31:0] MEM_WB_WriteData;
  logic [1:0]  ID_EX_wb;
  logic [2:0]  ID_EX_m;
  logic [3:0]  ID_EX_ex;
  logic [31:0] ID_EX_npc;
  logic [31:0] ID_EX_readdat1;
  logic [31:0] ID_EX_readdat2;
  logic [31:0] ID_EX_sign_ext;
  logic [4:0]  ID_EX_rs;
  logic [4:0]  ID_EX_rt;
  logic [4:0]  ID_EX_rd;
  logic        stall;

  int n_cmp;
  int n_bad;

  i_decode dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .IF_ID_instr      (IF_ID_instr),
    .IF_ID_npc        (IF_ID_npc),
    .MEM_WB_RegWrite  (MEM_WB_RegWrite),
    .MEM_WB_WriteReg  (MEM_WB_WriteReg),
    .MEM_WB_WriteData (MEM_WB_WriteData),
    .ID_EX_wb         (ID_EX_wb),
    .ID_EX_m          (ID_EX_m),
    .ID_EX_ex         (ID_EX_ex),
    .ID_EX_npc        (ID_EX_npc),
    .ID_EX_readdat1   (ID_EX_readdat1),
    .ID_EX_readdat2   (ID_EX_readdat2),
    .ID_EX_sign_ext   (ID_EX_sign_ext),
    .ID_EX_rs         (ID_EX_rs),
    .ID_EX_rt         (ID_EX_rt),
    .ID_EX_rd         (ID_EX_rd),
    .stall            (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic exp_stall;
  logic [1:0] exp_bub_wb;
  logic [2:0] exp_bub_m;
  logic [3:0] exp_bub_ex;

  initial begin
    n_cmp = 0;
    n_bad = 0;
`ifdef LOAD_USE_HAZARD_EN
    exp_stall  = 1'b1;
    exp_bub_wb = 2'b00;
    exp_bub_m  = 3'b000;
    exp_bub_ex = 4'b0000;
`else
    exp_stall  = 1'b0;
    exp_bub_wb = 2'b10;
    exp_bub_m  = 3'b000;
    exp_bub_ex = 4'b1100;
`endif

    // Reset with a lw in IF/ID and a writeback to $2 that must be dropped
    rst_n            = 1'b0;
    IF_ID_instr      = 32'h8C220004;
    IF_ID_npc        = 32'h00000004;
    MEM_WB_RegWrite  = 1'b1;
    MEM_WB_WriteReg  = 5'd2;
    MEM_WB_WriteData = 32'hAAAA5555;
    step();
    step();
    chk("rst_wb",   32'(ID_EX_wb), 32'h0);
    chk("rst_m",    32'(ID_EX_m), 32'h0);
    chk("rst_ex",   32'(ID_EX_ex), 32'h0);
    chk("rst_npc",  ID_EX_npc, 32'h0);
    chk("rst_rd1",  ID_EX_readdat1, 32'h0);
    chk("rst_rd2",  ID_EX_readdat2, 32'h0);
    chk("rst_sext", ID_EX_sign_ext, 32'h0);
    chk("rst_idx",  32'({ID_EX_rs, ID_EX_rt, ID_EX_rd}), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);

    // Read $2 after reset: add $2,$2,$0
    rst_n           = 1'b1;
    MEM_WB_RegWrite = 1'b0;
    IF_ID_instr     = 32'h00401020;
    step();
    chk("r2_after_rst", ID_EX_readdat1, 32'h0);
    chk("r2_rs", 32'(ID_EX_rs), 32'd2);

    // Writeback $5 while decoding a nop
    MEM_WB_RegWrite  = 1'b1;
    MEM_WB_WriteReg  = 5'd5;
    MEM_WB_WriteData = 32'hDEADBEEF;
    IF_ID_instr      = 32'h00000000;
    step();
    chk("nop_wb", 32'(ID_EX_wb), 32'h2);
    chk("nop_ex", 32'(ID_EX_ex), 32'hC);

    // add $6,$5,$5
    MEM_WB_RegWrite = 1'b0;
    IF_ID_instr     = 32'h00A53020;
    step();
    chk("add_rd1", ID_EX_readdat1, 32'hDEADBEEF);
    chk("add_rd2", ID_EX_readdat2, 32'hDEADBEEF);
    chk("add_wb",  32'(ID_EX_wb), 32'h2);
    chk("add_m",   32'(ID_EX_m), 32'h0);
    chk("add_ex",  32'(ID_EX_ex), 32'hC);
    chk("add_rd",  32'(ID_EX_rd), 32'd6);
    chk("add_rs",  32'(ID_EX_rs), 32'd5);

    // Bypass: write $3 while decoding beq $3,$3,2
    MEM_WB_RegWrite  = 1'b1;
    MEM_WB_WriteReg  = 5'd3;
    MEM_WB_WriteData = 32'h12345678;
    IF_ID_instr      = 32'h10630002;
    step();
    chk("byp_rd1",  ID_EX_readdat1, 32'h12345678);
    chk("byp_rd2",  ID_EX_readdat2, 32'h12345678);
    chk("byp_m",    32'(ID_EX_m), 32'h4);
    chk("byp_ex",   32'(ID_EX_ex), 32'h2);
    chk("byp_wb",   32'(ID_EX_wb), 32'h0);
    chk("byp_sext", ID_EX_sign_ext, 32'h00000002);

    // $0 protection, both in the bypass cycle and afterwards
    MEM_WB_RegWrite  = 1'b1;
    MEM_WB_WriteReg  = 5'd0;
    MEM_WB_WriteData = 32'hFFFFFFFF;
    IF_ID_instr      = 32'h00000020;
    step();
    chk("z0_byp_rd1", ID_EX_readdat1, 32'h0);
    chk("z0_byp_rd2", ID_EX_readdat2, 32'h0);
    MEM_WB_RegWrite = 1'b0;
    step();
    chk("z0_rd1", ID_EX_readdat1, 32'h0);
    chk("z0_rd2", ID_EX_readdat2, 32'h0);

    // lw $1,-4($2) with npc 0x10
    IF_ID_instr = 32'h8C41FFFC;
    IF_ID_npc   = 32'h00000010;
    step();
    chk("lw_sext", ID_EX_sign_ext, 32'hFFFFFFFC);
    chk("lw_ex",   32'(ID_EX_ex), 32'h1);
    chk("lw_m",    32'(ID_EX_m), 32'h2);
    chk("lw_wb",   32'(ID_EX_wb), 32'h3);
    chk("lw_npc",  ID_EX_npc, 32'h00000010);
    chk("lw_rt",   32'(ID_EX_rt), 32'd1);
    chk("lw_rs",   32'(ID_EX_rs), 32'd2);

    // Illegal opcode bubble; its rs/rt are $0 so no stall against the lw above
    IF_ID_instr = 32'hFC000000;
    IF_ID_npc   = 32'h00000014;
    #1;
    chk("ill_stall", 32'(stall), 32'h0);
    step();
    chk("ill_ctl", 32'({ID_EX_wb, ID_EX_m, ID_EX_ex}), 32'h0);
    chk("ill_sext", ID_EX_sign_ext, 32'h0);

    // sw $1,8($2)
    IF_ID_instr = 32'hAC410008;
    step();
    chk("sw_ctl", 32'({ID_EX_wb, ID_EX_m, ID_EX_ex}), 32'b00_001_0001);

    // Load-use: lw $1,0($2) then add $3,$1,$4
    IF_ID_instr = 32'h8C410000;
    step();
    chk("lu_lw_m", 32'(ID_EX_m), 32'h2);
    IF_ID_instr = 32'h00241820;
    #1;
    chk("lu_stall", 32'(stall), 32'(exp_stall));
    step();
    chk("lu_bub_wb", 32'(ID_EX_wb), 32'(exp_bub_wb));
    chk("lu_bub_m",  32'(ID_EX_m), 32'(exp_bub_m));
    chk("lu_bub_ex", 32'(ID_EX_ex), 32'(exp_bub_ex));
    chk("lu_bub_rs", 32'(ID_EX_rs), 32'd1);
    chk("lu_bub_rd", 32'(ID_EX_rd), 32'd3);
    chk("lu_stall_clr", 32'(stall), 32'h0);
    step();
    chk("lu_add_ctl", 32'({ID_EX_wb, ID_EX_m, ID_EX_ex}), 32'b10_000_1100);
    chk("lu_stall_end", 32'(stall), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
